// File: rtl/fifo_pkg.sv
// Shared state encoding and frame constants for the FIFO transmit serializer.
package fifo_pkg;

  localparam int WIDTH_DEFAULT        = 4;
  localparam int CLKS_PER_BIT_DEFAULT = 4;
  // start + data + parity + stop, in bit periods, at the default word width
  localparam int FRAME_BITS           = WIDTH_DEFAULT + 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_t;

  function automatic int frame_bits(input int width);
    return width + 3;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: one-cycle tick every CLKS_PER_BIT cycles while enabled,
// reloaded whenever disabled so each enable starts a full period.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick
);

  localparam logic [7:0] RELOAD = 8'(CLKS_PER_BIT - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= RELOAD;
    end else if (!i_en || r_cnt == 8'd0) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_tick = i_en && (r_cnt == 8'd0);

endmodule

// File: rtl/fifo_tx_serializer.sv
// Pops words from an upstream FIFO and sends them as start / LSB-first data /
// even parity / stop frames on an idle-high serial line.
//
// state  | meaning
// IDLE   | line high, waiting for enable with a non-empty FIFO
// POP    | one-cycle fifo_read pulse
// LOAD   | FIFO read data valid, captured into the shift register
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | even parity of the word
// STOP   | stop bit (high); frame counted on exit
module fifo_tx_serializer
  import fifo_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEFAULT,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_read,
  output logic             tx_out,
  output logic             busy,
  output logic [7:0]       frames_sent
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_shift;
  logic [IDX_W-1:0]   r_bit_idx;
  logic               r_parity;
  logic [7:0]         r_frames;
  logic               w_baud_en;
  logic               w_tick;
  logic               w_last_bit;

  assign w_baud_en  = (r_state == ST_START) || (r_state == ST_DATA) ||
                      (r_state == ST_PARITY) || (r_state == ST_STOP);
  assign w_last_bit = (r_bit_idx == IDX_W'(WIDTH - 1));

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_en    (w_baud_en),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (enable && !fifo_empty) w_state_nxt = ST_POP;
      ST_POP:    w_state_nxt = ST_LOAD;
      ST_LOAD:   w_state_nxt = ST_START;
      ST_START:  if (w_tick) w_state_nxt = ST_DATA;
      ST_DATA:   if (w_tick && w_last_bit) w_state_nxt = ST_PARITY;
      ST_PARITY: if (w_tick) w_state_nxt = ST_STOP;
      ST_STOP:   if (w_tick) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_parity  <= 1'b0;
      r_frames  <= 8'd0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_shift   <= fifo_data;
          r_bit_idx <= '0;
          r_parity  <= ^fifo_data;
        end
        ST_DATA: begin
          if (w_tick && !w_last_bit) begin
            r_shift   <= r_shift >> 1;
            r_bit_idx <= r_bit_idx + IDX_W'(1);
          end
        end
        ST_STOP: begin
          if (w_tick) r_frames <= r_frames + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx_out = 1'b1;
    case (r_state)
      ST_START:  tx_out = 1'b0;
      ST_DATA:   tx_out = r_shift[0];
      ST_PARITY: tx_out = r_parity;
      default:   tx_out = 1'b1;
    endcase
  end

  assign fifo_read   = (r_state == ST_POP);
  assign busy        = (r_state != ST_IDLE);
  assign frames_sent = r_frames;

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Scoreboard bench: words pushed into a behavioural FIFO queue their expected
// frames; a line monitor pops and checks each frame bit-period by bit-period.
module tb_fifo_tx_serializer;

  localparam int W         = 4;
  localparam int CPB       = 4;
  localparam int FRAME_CYC = (W + 3) * CPB;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         fifo_empty;
  logic [W-1:0] fifo_data;
  logic         fifo_read;
  logic         tx_out;
  logic         busy;
  logic [7:0]   frames_sent;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] fifo_mem [0:511];
  int           pushed_cnt = 0;
  int           popped_cnt = 0;

  logic [W-1:0] exp_q [$];
  int           gap_q [$];

  bit           mon_active = 1'b0;
  int           mon_cyc = 0;
  logic [W-1:0] mon_word = '0;
  int           idle_run = 0;
  bit           have_prev = 1'b0;
  bit           prev_rd = 1'b0;
  int           frames_seen = 0;
  int           rd_cnt = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (pushed_cnt == popped_cnt);

  fifo_tx_serializer #(
    .WIDTH        (W),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_read   (fifo_read),
    .tx_out      (tx_out),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [W-1:0] w, input int idx);
    if (idx == 0) return 1'b0;
    else if (idx <= W) return w[idx-1];
    else if (idx == W + 1) return ^w;
    else return 1'b1;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] w);
    fifo_mem[pushed_cnt % 512] = w;
    pushed_cnt++;
    exp_q.push_back(w);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_seen < target && n < budget) begin
      tick();
      n++;
    end
    chk("frame_wait", (frames_seen >= target), 1);
  endtask

  task automatic wait_mon_cyc(input int cyc, input int budget);
    int n = 0;
    while (!(mon_active && mon_cyc == cyc) && n < budget) begin
      tick();
      n++;
    end
    chk("reach_frame_cycle", (mon_active && mon_cyc == cyc), 1);
  endtask

  task automatic apply_reset();
    enable = 1'b0;
    reset  = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    gap_q.delete();
    tick();
  endtask

  // upstream FIFO: registered read data, valid the cycle after the pop
  initial begin
    fifo_data = '0;
    forever begin
      @(posedge clk);
      if (fifo_read === 1'b1) begin
        fifo_data  <= fifo_mem[popped_cnt % 512];
        popped_cnt <= popped_cnt + 1;
      end
    end
  end

  // line monitor and scoreboard consumer
  initial begin
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        mon_active = 1'b0;
        mon_cyc    = 0;
        idle_run   = 0;
        have_prev  = 1'b0;
        prev_rd    = 1'b0;
      end else begin
        if (fifo_read === 1'b1) begin
          chk("read_single_cycle", prev_rd, 0);
          chk("read_while_empty", fifo_empty, 0);
          rd_cnt++;
        end
        prev_rd = (fifo_read === 1'b1);
        if (!mon_active) begin
          if (tx_out === 1'b0) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_frame", 1, 0);
              mon_word = '0;
            end else begin
              mon_word = exp_q.pop_front();
            end
            if (have_prev) gap_q.push_back(idle_run);
            mon_active = 1'b1;
            mon_cyc    = 0;
          end else begin
            idle_run++;
          end
        end
        if (mon_active) begin
          chk("tx_bit", tx_out, frame_bit(mon_word, mon_cyc / CPB));
          chk("busy_in_frame", busy, 1);
          if (mon_cyc == FRAME_CYC - 1) begin
            mon_active = 1'b0;
            frames_seen++;
            have_prev = 1'b1;
            idle_run  = 0;
          end else begin
            mon_cyc++;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rd0;
    int f0;
    int bad_rd;
    int bad_tx;
    int bad_busy;

    reset  = 1'b0;
    enable = 1'b0;
    repeat (3) tick();
    chk("rst_tx_out", tx_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_read", fifo_read, 0);
    chk("rst_frames_sent", frames_sent, 0);
    reset = 1'b1;
    tick();

    // empty FIFO with enable held: nothing happens
    enable   = 1'b1;
    bad_rd   = 0;
    bad_tx   = 0;
    bad_busy = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (fifo_read !== 1'b0) bad_rd++;
      if (tx_out !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
    end
    chk("empty_read_cycles", bad_rd, 0);
    chk("empty_tx_low_cycles", bad_tx, 0);
    chk("empty_busy_cycles", bad_busy, 0);

    // single word 1011: line 0,1,1,0,1,1,1
    apply_reset();
    rd0 = rd_cnt;
    f0  = frames_seen;
    push(4'b1011);
    enable = 1'b1;
    wait_frames(f0 + 1, 100);
    tick();
    tick();
    chk("single_reads", rd_cnt - rd0, 1);
    chk("single_frames_sent", frames_sent, 1);
    chk("single_busy_after", busy, 0);
    chk("single_tx_idle", tx_out, 1);

    // three words back to back
    apply_reset();
    rd0 = rd_cnt;
    f0  = frames_seen;
    push(4'b0101);
    push(4'b1100);
    push(4'b0110);
    enable = 1'b1;
    wait_frames(f0 + 3, 200);
    tick();
    tick();
    chk("b2b_frames_sent", frames_sent, 3);
    chk("b2b_reads", rd_cnt - rd0, 3);
    chk("b2b_gap_count", gap_q.size(), 2);
    while (gap_q.size() > 0) chk("b2b_gap", gap_q.pop_front(), 3);

    // enable dropped during data bit 1: frame finishes, second word stays queued
    apply_reset();
    rd0 = rd_cnt;
    f0  = frames_seen;
    push(4'b0110);
    push(4'b1001);
    enable = 1'b1;
    wait_mon_cyc(CPB + 6, 60);
    enable = 1'b0;
    wait_frames(f0 + 1, 60);
    repeat (10) tick();
    chk("drop_frames_sent", frames_sent, 1);
    chk("drop_reads", rd_cnt - rd0, 1);
    chk("drop_busy", busy, 0);
    chk("drop_fifo_left", fifo_empty, 0);
    chk("drop_pending_frames", exp_q.size(), 1);
    enable = 1'b1;
    wait_frames(f0 + 2, 100);
    tick();
    tick();
    chk("resume_frames_sent", frames_sent, 2);

    // reset during parity: frame discarded, counter cleared
    rd0 = rd_cnt;
    f0  = frames_seen;
    push(4'b1110);
    wait_mon_cyc((W + 1) * CPB + 1, 60);
    reset = 1'b0;
    #1;
    chk("parity_rst_tx_out", tx_out, 1);
    chk("parity_rst_busy", busy, 0);
    chk("parity_rst_frames_sent", frames_sent, 0);
    chk("parity_rst_fifo_read", fifo_read, 0);
    tick();
    tick();
    reset = 1'b1;
    repeat (40) tick();
    chk("post_rst_frames_sent", frames_sent, 0);
    chk("post_rst_reads", rd_cnt - rd0, 1);
    chk("post_rst_frames_seen", frames_seen - f0, 0);
    chk("post_rst_busy", busy, 0);

    // 256 frames: counter wraps
    apply_reset();
    f0 = frames_seen;
    for (int i = 0; i < 256; i++) push(W'($urandom_range(0, (1 << W) - 1)));
    enable = 1'b1;
    wait_frames(f0 + 255, 255 * (FRAME_CYC + 3) + 100);
    tick();
    chk("wrap_frames_sent_255", frames_sent, 255);
    wait_frames(f0 + 256, 100);
    tick();
    tick();
    chk("wrap_frames_sent_0", frames_sent, 0);
    chk("wrap_gap_count", gap_q.size(), 255);
    while (gap_q.size() > 0) chk("wrap_gap", gap_q.pop_front(), 3);
    enable = 1'b0;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
